axis_master_unpack: RTL

Parametrised AXI4-Stream master that reads a runtime-programmed range of wide words from an external output memory, unpacks each word MSB-first into `R = VLW_WDT/TDATA_WDT` narrower beats, buffers them in an internal FIFO, and streams them out with correct TLAST, TID and backpressure. It sits between the accelerator's output memory and the DMA-facing AXI-Stream port. It supersedes the fixed-length, fixed-width output interface and adds:

- runtime base address and length,
- any power-of-two width ratio including 1,
- a per-transfer TID,
- abort,
- a 1-beat-per-cycle sustained rate.

---
 rtl/axis_master_unpack.sv | 133 +++++++++++++
 1 files changed

// File: rtl/axis_master_unpack.sv
// axis_master_unpack: reads a programmed range of wide memory words and streams them
// as MSB-first AXI4-Stream beats through a beat FIFO.
module axis_master_unpack #(
  parameter int VLW_WDT = 256,
  parameter int TDATA_WDT = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WDT = 10,
  parameter int LEN_WDT = 12,
  parameter int TID_WDT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [ADDR_WDT-1:0]  tx_base_addr,
  input  logic [LEN_WDT-1:0]   tx_len,
  input  logic [TID_WDT-1:0]   tx_tid,
  input  logic                 tx_abort,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_aborted,
  output logic                 mem_rd_en,
  output logic [ADDR_WDT-1:0]  mem_addr,
  input  logic [VLW_WDT-1:0]   mem_rd_data,
  output logic [TDATA_WDT-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  output logic [TID_WDT-1:0]   M_AXIS_TID,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY
);
  localparam int R = VLW_WDT / TDATA_WDT;
  localparam int CW = $clog2(R + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ABORT, DONE} state_t;
  state_t state;
  logic [ADDR_WDT-1:0] base;
  logic [LEN_WDT-1:0] len, issued;
  logic aborted, inflight, inflight_last, word_last;
  logic [VLW_WDT-1:0] slots;
  logic [CW-1:0] cnt;
  logic [TDATA_WDT:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count, count_nxt;
  logic [CW:0] n1;
  logic active, flush, push, pop, rd_en;
  assign active = state == RUN || state == DRAIN;
  assign flush = active && tx_abort;
  assign push = cnt != '0 && !count[PW];
  assign pop = active && !tx_abort && count != '0 && (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  // n1 is the unpacker occupancy after this edge; a read issued now lands one cycle later,
  // so it is safe when n1 is 0, or 1 with a guaranteed push next cycle
  assign n1 = (CW+1)'(cnt) - (CW+1)'(push) + (inflight ? (CW+1)'(R) : '0);
  assign rd_en = state == RUN && !tx_abort && issued != len &&
                 (n1 == '0 || (n1 == (CW+1)'(1) && !count_nxt[PW]));
  assign mem_rd_en = rd_en;
  assign mem_addr = base + ADDR_WDT'(issued);
  assign tx_busy = state != IDLE;
  assign tx_done = state == DONE;
  assign tx_aborted = state == DONE && aborted;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      issued <= '0;
      M_AXIS_TID <= '0;
      aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          base <= tx_base_addr;
          len <= tx_len;
          M_AXIS_TID <= tx_tid;
          issued <= '0;
          aborted <= 1'b0;
          state <= tx_len == '0 ? DONE : RUN;
        end
        RUN: state <= tx_abort ? ABORT : issued == len && cnt == '0 && !inflight ? DRAIN : RUN;
        DRAIN: state <= tx_abort ? ABORT : M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST ? DONE : DRAIN;
        ABORT: if (!M_AXIS_TVALID || M_AXIS_TREADY) begin
          state <= DONE;
          aborted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (rd_en) issued <= issued + LEN_WDT'(1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slots <= '0;
      cnt <= '0;
      word_last <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= rd_en;
      inflight_last <= issued == len - LEN_WDT'(1);
      if (flush) cnt <= '0;
      else if (inflight) begin
        slots <= mem_rd_data;
        cnt <= CW'(R);
        word_last <= inflight_last;
      end else if (push) begin
        slots <= slots << TDATA_WDT;
        cnt <= cnt - CW'(1);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count_nxt;
    end
  always_ff @(posedge clk)
    if (push && !flush) fifo[wp] <= {word_last && cnt == CW'(1), slots[VLW_WDT-1 -: TDATA_WDT]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      M_AXIS_TDATA <= '0;
      M_AXIS_TLAST <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else if (pop) begin
      {M_AXIS_TLAST, M_AXIS_TDATA} <= fifo[rp];
      M_AXIS_TVALID <= 1'b1;
    end else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
endmodule
